// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults and response-owner encoding for the data-memory arbiter.
package dmem_pkg;
    localparam int DMEM_ADDR_W     = 16;
    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_STARVE_LIM = 8;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_e;
endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: saturating host-starvation counter with clear, increment and limit flag.
module dmem_starve_ctr #(
    parameter int LIM = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt,
    output logic       at_lim
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : (inc && cnt_q != 8'(LIM)) ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt    = cnt_q;
    assign at_lim = cnt_q == 8'(LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data-memory port between the CPU LSU and the host port.
// CPU has priority; the starvation counter forces a host slot under sustained CPU traffic.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_LIM = DMEM_STARVE_LIM
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    input  logic              host_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        starve_cnt
);
    logic              at_lim, host_win, cpu_win, any_gnt, mis, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    owner_e            own_q, own_d;
    logic              mis_q, mis_d;

    // Grants are gated by reset_n so every output reads zero while reset is held.
    always_comb begin
        host_win  = reset_n & host_req & (host_hold | ~cpu_req | at_lim);
        cpu_win   = reset_n & ~host_win & cpu_req & ~host_hold;
        any_gnt   = host_win | cpu_win;
        sel_we    = host_win ? host_we : cpu_we;
        sel_addr  = host_win ? host_addr : cpu_addr;
        sel_wdata = host_win ? host_wdata : cpu_wdata;
        mis       = sel_addr[1:0] != 2'b00;
        own_d     = host_win ? OWN_HOST : cpu_win ? OWN_CPU : OWN_NONE;
        mis_d     = any_gnt & mis;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            own_q <= OWN_NONE;
            mis_q <= 1'b0;
        end else begin
            own_q <= own_d;
            mis_q <= mis_d;
        end
    end

    always_comb begin
        cpu_gnt     = cpu_win;
        host_gnt    = host_win;
        mem_en      = any_gnt & ~mis;
        mem_we      = any_gnt & ~mis & sel_we;
        mem_addr    = any_gnt ? sel_addr : '0;
        mem_wdata   = any_gnt ? sel_wdata : '0;
        cpu_rvalid  = own_q == OWN_CPU;
        host_rvalid = own_q == OWN_HOST;
        cpu_err     = cpu_rvalid & mis_q;
        host_err    = host_rvalid & mis_q;
        cpu_rdata   = (cpu_rvalid & ~mis_q) ? mem_rdata : '0;
        host_rdata  = (host_rvalid & ~mis_q) ? mem_rdata : '0;
    end

    dmem_starve_ctr #(.LIM(STARVE_LIM)) u_starve (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .clr    (host_win | ~host_req),
        .inc    (host_req & ~host_win),
        .cnt    (starve_cnt),
        .at_lim (at_lim)
    );
endmodule
